// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants: hazard FSM encoding, EX operand forward selects, x0.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_LDSTALL = 2'd1,
        HZ_FLUSH   = 2'd2,
        HZ_MEMWAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when a writing stage targets rs; x0 is hardwired so never matches.
    function automatic logic rd_hit(input logic wr_en, input logic [4:0] rd, input logic [4:0] rs);
        return wr_en && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard control bundle: register ids/flags in, hold/bubble enables and forward selects out.
// Latency: n/a (wires only).
// Backpressure: n/a.
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       ex_reg_write;
    logic       ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic       mem_load;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       dmem_busy;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_load,
               ex_reg_write, ex_redirect, mem_rd, mem_reg_write, mem_load, wb_rd,
               wb_reg_write, dmem_busy,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
               fwd_a_sel, fwd_b_sel
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_load,
               ex_reg_write, ex_redirect, mem_rd, mem_reg_write, mem_load, wb_rd,
               wb_reg_write, dmem_busy,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
               fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// EX operand forward select for one source register; EX/MEM beats MEM/WB, loads in MEM are not forwardable.
// Latency: combinational.
// Backpressure: none.
module forward_sel
    import rv32i_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       mem_load,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        // Load data is not ready in MEM; the load-use stall guarantees it arrives via MEM/WB.
        if (rd_hit(mem_reg_write && !mem_load, mem_rd, ex_rs)) begin
            sel = FWD_EXMEM;
        end else if (rd_hit(wb_reg_write, wb_rd, ex_rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I hazard control: load-use stall, redirect flush, dmem-wait hold, EX forwarding; HAZARD_PERF_EN adds counters.
// Latency: outputs combinational from state and inputs; state advances on posedge clk.
// Backpressure: dmem_busy holds all four pipe registers and freezes the flush sequence.
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
    , output logic [CNT_W-1:0] perf_ldstall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_memwait
`endif
);

    localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

    hz_state_t  st_q, st_d, eff_st;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       ret_flush_q, ret_flush_d;
    logic       load_use, take_redirect, take_ldstall;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    forward_sel u_fwd_a (
        .ex_rs(hz.ex_rs1), .mem_rd(hz.mem_rd), .mem_reg_write(hz.mem_reg_write),
        .mem_load(hz.mem_load), .wb_rd(hz.wb_rd), .wb_reg_write(hz.wb_reg_write), .sel(fwd_a_raw)
    );

    forward_sel u_fwd_b (
        .ex_rs(hz.ex_rs2), .mem_rd(hz.mem_rd), .mem_reg_write(hz.mem_reg_write),
        .mem_load(hz.mem_load), .wb_rd(hz.wb_rd), .wb_reg_write(hz.wb_reg_write), .sel(fwd_b_raw)
    );

    // Once busy drops, behave in that same cycle as the state we were parked in.
    assign eff_st = (st_q == HZ_MEMWAIT) ? (ret_flush_q ? HZ_FLUSH : HZ_RUN) : st_q;

    assign load_use = hz.ex_load && hz.ex_reg_write && (hz.ex_rd != REG_X0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    assign take_redirect = !hz.dmem_busy && hz.ex_redirect &&
                           ((eff_st == HZ_RUN) || (eff_st == HZ_LDSTALL));
    assign take_ldstall  = !hz.dmem_busy && !hz.ex_redirect && (eff_st == HZ_RUN) && load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= HZ_RUN;
            flush_cnt_q <= '0;
            ret_flush_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            flush_cnt_q <= flush_cnt_d;
            ret_flush_q <= ret_flush_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        flush_cnt_d = flush_cnt_q;
        ret_flush_d = ret_flush_q;
        if (hz.dmem_busy) begin
            st_d = HZ_MEMWAIT;
            if (st_q != HZ_MEMWAIT) begin
                ret_flush_d = (st_q == HZ_FLUSH);
            end
        end else if (take_redirect) begin
            if (FLUSH_CYCLES == 1) begin
                st_d        = HZ_RUN;
                flush_cnt_d = '0;
            end else begin
                st_d        = HZ_FLUSH;
                flush_cnt_d = FC_INIT;
            end
        end else if (take_ldstall) begin
            st_d = HZ_LDSTALL;
        end else if (eff_st == HZ_FLUSH) begin
            flush_cnt_d = (flush_cnt_q <= 3'd1) ? 3'd0 : flush_cnt_q - 3'd1;
            st_d        = (flush_cnt_q <= 3'd1) ? HZ_RUN : HZ_FLUSH;
        end else begin
            st_d = HZ_RUN;
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        fwd_a_sel    = FWD_RF;
        fwd_b_sel    = FWD_RF;
        if (rst) begin
            fwd_a_sel = fwd_a_raw;
            fwd_b_sel = fwd_b_raw;
            if (hz.dmem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (take_redirect || (eff_st == HZ_FLUSH)) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (take_ldstall) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.ex_mem_stall = ex_mem_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.fwd_a_sel    = fwd_a_sel;
    assign hz.fwd_b_sel    = fwd_b_sel;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_ldstall_q, perf_ldstall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic [CNT_W-1:0] perf_memwait_q, perf_memwait_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        perf_ldstall_d = sat_inc(perf_ldstall_q, take_ldstall);
        perf_flush_d   = sat_inc(perf_flush_q, take_redirect);
        perf_memwait_d = sat_inc(perf_memwait_q, hz.dmem_busy);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ldstall_q <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
        end else begin
            perf_ldstall_q <= perf_ldstall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign perf_ldstall = perf_ldstall_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors queued at drive time, compared on the falling edge.
module tb_hazard_ctrl;

    logic clk;
    logic rst;

    hazard_ctrl_if hzif ();

`ifdef HAZARD_PERF_EN
    logic [3:0] perf_ldstall;
    logic [3:0] perf_flush;
    logic [3:0] perf_memwait;
`endif

    hazard_ctrl #(
        .FLUSH_CYCLES(2)
`ifdef HAZARD_PERF_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hzif)
`ifdef HAZARD_PERF_EN
        , .perf_ldstall(perf_ldstall),
        .perf_flush(perf_flush),
        .perf_memwait(perf_memwait)
`endif
    );

    // {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex flushes, fwd_a, fwd_b}
    localparam logic [9:0] E_NONE  = 10'b00_00_00_0000;
    localparam logic [9:0] E_LDUSE = 10'b11_00_01_0000;
    localparam logic [9:0] E_FLUSH = 10'b00_00_11_0000;
    localparam logic [9:0] E_BUSY  = 10'b11_11_00_0000;

    logic [9:0] obs;
    assign obs = {hzif.pc_stall, hzif.if_id_stall, hzif.id_ex_stall, hzif.ex_mem_stall,
                  hzif.if_id_flush, hzif.id_ex_flush, hzif.fwd_a_sel, hzif.fwd_b_sel};

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];
    string      tag_q[$];
    logic [4:0] r_a, r_b, r_m, r_w;
    logic       f_m, f_l, f_w;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic exp_push(input string tag, input logic [9:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hzif.id_rs1 = '0; hzif.id_rs2 = '0; hzif.id_use_rs1 = 0; hzif.id_use_rs2 = 0;
        hzif.ex_rs1 = '0; hzif.ex_rs2 = '0; hzif.ex_rd = '0; hzif.ex_load = 0;
        hzif.ex_reg_write = 0; hzif.ex_redirect = 0; hzif.mem_rd = '0; hzif.mem_reg_write = 0;
        hzif.mem_load = 0; hzif.wb_rd = '0; hzif.wb_reg_write = 0; hzif.dmem_busy = 0;
    endtask

    task automatic set_load_use();
        hzif.ex_load = 1; hzif.ex_reg_write = 1; hzif.ex_rd = 5'd5;
        hzif.id_rs1 = 5'd5; hzif.id_use_rs1 = 1;
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] mrd,
                                             input logic mw, input logic ml,
                                             input logic [4:0] wrd, input logic ww);
        if (rs != 5'd0 && mw && !ml && mrd == rs) return 2'b01;
        if (rs != 5'd0 && ww && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 0;
        rst = 0;
        clear_in();
        set_load_use();
        hzif.dmem_busy = 1; hzif.ex_redirect = 1;
        #3 check("reset_out", 32'(obs), 32'(E_NONE));
        tick();
        check("reset_hold", 32'(obs), 32'(E_NONE));
        rst = 1; clear_in();
        exp_push("idle", E_NONE);

        // load-use: one stall cycle, no re-detect in LDSTALL, then RUN re-detects
        tick(); set_load_use();             exp_push("ldu_stall", E_LDUSE);
        tick();                             exp_push("ldu_once", E_NONE);
        tick();                             exp_push("ldu_again", E_LDUSE);
        tick(); clear_in();                 exp_push("ldu_done", E_NONE);
        tick(); hzif.ex_load = 1; hzif.ex_reg_write = 1; hzif.id_use_rs1 = 1;
                                            exp_push("ldu_x0", E_NONE);
        tick(); hzif.ex_rd = 5'd7; hzif.id_rs1 = 5'd7; hzif.id_use_rs1 = 0;
                                            exp_push("ldu_nouse", E_NONE);
        tick(); hzif.id_rs2 = 5'd7; hzif.id_use_rs2 = 1;
                                            exp_push("ldu_rs2", E_LDUSE);
        tick(); clear_in();                 exp_push("ldu_rs2_done", E_NONE);
        tick(); hzif.ex_reg_write = 1; hzif.ex_rd = 5'd7; hzif.id_rs1 = 5'd7; hzif.id_use_rs1 = 1;
                                            exp_push("alu_dep", E_NONE);

        // redirect: exactly two flush cycles, redirect held in FLUSH is ignored
        tick(); clear_in(); hzif.ex_redirect = 1; exp_push("redir_c0", E_FLUSH);
        tick(); hzif.ex_redirect = 0;       exp_push("redir_c1", E_FLUSH);
        tick();                             exp_push("redir_end", E_NONE);
        tick(); hzif.ex_redirect = 1;       exp_push("redir_hold_c0", E_FLUSH);
        tick();                             exp_push("redir_hold_c1", E_FLUSH);
        tick(); hzif.ex_redirect = 0;       exp_push("redir_hold_end", E_NONE);
        tick(); set_load_use(); hzif.ex_redirect = 1; exp_push("redir_over_ldu", E_FLUSH);
        tick(); clear_in();                 exp_push("redir_over_ldu_c1", E_FLUSH);
        tick();                             exp_push("redir_over_ldu_end", E_NONE);

        // forwarding priority and x0
        tick(); hzif.ex_rs1 = 5'd3; hzif.mem_rd = 5'd3; hzif.mem_reg_write = 1;
                hzif.wb_rd = 5'd3; hzif.wb_reg_write = 1; exp_push("fwd_exmem", 10'b00_00_00_0100);
        tick(); hzif.mem_load = 1;          exp_push("fwd_memwb", 10'b00_00_00_1000);
        tick(); hzif.ex_rs1 = 5'd0;         exp_push("fwd_x0", E_NONE);
        tick(); hzif.ex_rs2 = 5'd3; hzif.mem_load = 0; exp_push("fwd_b", 10'b00_00_00_0001);
        for (int i = 0; i < 16; i++) begin
            r_a = 5'($urandom_range(0, 3)); r_b = 5'($urandom_range(0, 3));
            r_m = 5'($urandom_range(0, 3)); r_w = 5'($urandom_range(0, 3));
            f_m = 1'($urandom_range(0, 1)); f_l = 1'($urandom_range(0, 1)); f_w = 1'($urandom_range(0, 1));
            tick();
            hzif.ex_rs1 = r_a; hzif.ex_rs2 = r_b; hzif.mem_rd = r_m; hzif.mem_reg_write = f_m;
            hzif.mem_load = f_l; hzif.wb_rd = r_w; hzif.wb_reg_write = f_w;
            exp_push("fwd_rand", {6'b0, fwd_model(r_a, r_m, f_m, f_l, r_w, f_w),
                                  fwd_model(r_b, r_m, f_m, f_l, r_w, f_w)});
        end

        // dmem_busy over redirect, then the flush sequence starts when busy drops
        for (int i = 0; i < 3; i++) begin
            tick(); clear_in(); hzif.dmem_busy = 1; hzif.ex_redirect = 1;
            exp_push("busy_redir", E_BUSY);
        end
        tick(); hzif.dmem_busy = 0;         exp_push("busy_drop_c0", E_FLUSH);
        tick(); hzif.ex_redirect = 0;       exp_push("busy_drop_c1", E_FLUSH);
        tick();                             exp_push("busy_drop_end", E_NONE);
        // busy in the middle of a flush freezes and then resumes the count
        tick(); hzif.ex_redirect = 1;       exp_push("fl_busy_c0", E_FLUSH);
        tick(); hzif.ex_redirect = 0; hzif.dmem_busy = 1; exp_push("fl_busy_hold", E_BUSY);
        tick();                             exp_push("fl_busy_hold2", E_BUSY);
        tick(); hzif.dmem_busy = 0;         exp_push("fl_busy_resume", E_FLUSH);
        tick();                             exp_push("fl_busy_end", E_NONE);
        // busy over load-use, fwd still live; load-use fires once busy drops
        tick(); set_load_use(); hzif.dmem_busy = 1; hzif.ex_rs1 = 5'd3; hzif.mem_rd = 5'd3;
                hzif.mem_reg_write = 1;     exp_push("busy_ldu_fwd", 10'b11_11_00_0100);
        tick(); hzif.dmem_busy = 0;         exp_push("busy_ldu_drop", 10'b11_00_01_0100);
        tick(); clear_in();                 exp_push("busy_ldu_end", E_NONE);

        // asynchronous reset in the middle of a flush
        tick(); hzif.ex_redirect = 1;       exp_push("arst_pre", E_FLUSH);
        tick(); hzif.ex_redirect = 0; rst = 0;
        #1 check("arst_async", 32'(obs), 32'(E_NONE));
        hzif.dmem_busy = 1;
        #1 check("arst_hold", 32'(obs), 32'(E_NONE));
        tick(); rst = 1; clear_in();        exp_push("arst_release", E_NONE);
        tick();                             exp_push("arst_no_residual", E_NONE);

`ifdef HAZARD_PERF_EN
        tick(); rst = 0;
        tick(); rst = 1;                    exp_push("perf_idle", E_NONE);
        for (int i = 0; i < 4; i++) begin
            tick(); set_load_use();         exp_push("perf_ldu", E_LDUSE);
            tick(); clear_in();             exp_push("perf_ldu_gap", E_NONE);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); hzif.ex_redirect = 1;   exp_push("perf_redir", E_FLUSH);
            tick(); hzif.ex_redirect = 0;   exp_push("perf_redir_c1", E_FLUSH);
            tick();                         exp_push("perf_redir_end", E_NONE);
        end
        for (int i = 0; i < 10; i++) begin
            tick(); hzif.dmem_busy = 1;     exp_push("perf_busy", E_BUSY);
        end
        tick(); hzif.dmem_busy = 0;         exp_push("perf_busy_end", E_NONE);
        check("perf_ldstall", 32'(perf_ldstall), 32'd4);
        check("perf_flush", 32'(perf_flush), 32'd2);
        check("perf_memwait", 32'(perf_memwait), 32'd10);
        for (int i = 0; i < 6; i++) begin
            tick(); hzif.dmem_busy = 1;     exp_push("perf_busy_sat", E_BUSY);
        end
        tick(); hzif.dmem_busy = 0;         exp_push("perf_sat_end", E_NONE);
        check("perf_memwait_sat", 32'(perf_memwait), 32'd15);
        check("perf_ldstall_keep", 32'(perf_ldstall), 32'd4);
`endif

        tick();
        @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
